match_controller: RTL and testbench

//  Top-level match sequencer for the two-player fighting game. It steps the game

---
 rtl/match_controller.sv | 172 +++++++++++++++++
 tb/tb_match_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Match sequencer: IDLE -> INTRO -> PvP/PvAI fight -> GAME_OVER -> IDLE.
// Owns both health counters, the round clock and the winner flag; every output is registered.
module match_controller #(
    parameter int HP_W          = 4,
    parameter int HP_MAX        = 10,
    parameter int TICKS_PER_SEC = 60,
    parameter int ROUND_SEC     = 99,
    parameter int INTRO_TICKS   = 180,
    parameter int OVER_TICKS    = 300
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            start,
    input  logic            mode_ai,
    input  logic            p1_hit,
    input  logic            p2_hit,
    output logic [2:0]      state,
    output logic            players_rst,
    output logic            ai_en,
    output logic [HP_W-1:0] p1_hp,
    output logic [HP_W-1:0] p2_hp,
    output logic [6:0]      round_sec,
    output logic [1:0]      winner
);

    // One shared frame-tick counter, sized for the longest phase it has to time.
    localparam int CNT_MAX_A = (INTRO_TICKS > OVER_TICKS) ? INTRO_TICKS : OVER_TICKS;
    localparam int CNT_MAX   = (CNT_MAX_A > TICKS_PER_SEC) ? CNT_MAX_A : TICKS_PER_SEC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INTRO_LAST = CNT_W'(INTRO_TICKS - 1);
    localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_TICKS - 1);
    localparam logic [CNT_W-1:0] SEC_LAST   = CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [HP_W-1:0]  HP_INIT    = HP_W'(HP_MAX);
    localparam logic [6:0]       SEC_INIT   = 7'(ROUND_SEC);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INTRO = 3'd1,
        S_PVP   = 3'd2,
        S_PVAI  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t           state_q;
    logic             mode_q;
    logic [CNT_W-1:0] tick_cnt;

    logic [HP_W-1:0]  p1_hp_nx;
    logic [HP_W-1:0]  p2_hp_nx;
    logic [6:0]       round_sec_nx;
    logic [CNT_W-1:0] fight_cnt_nx;
    logic             sec_roll;
    logic             fight_end;
    logic [1:0]       winner_nx;

    assign state = state_q;

    // Fight-cycle next values: hits and the clock tick of the final cycle are
    // folded in before the end-of-fight test and the winner comparison.
    always_comb begin
        p1_hp_nx     = p1_hp;
        p2_hp_nx     = p2_hp;
        round_sec_nx = round_sec;
        fight_cnt_nx = tick_cnt;
        sec_roll     = tick && (tick_cnt == SEC_LAST);

        if (p2_hit && (p1_hp != '0)) begin
            p1_hp_nx = p1_hp - 1'b1;
        end
        if (p1_hit && (p2_hp != '0)) begin
            p2_hp_nx = p2_hp - 1'b1;
        end
        if (tick) begin
            fight_cnt_nx = sec_roll ? '0 : tick_cnt + 1'b1;
        end
        if (sec_roll && (round_sec != '0)) begin
            round_sec_nx = round_sec - 1'b1;
        end

        fight_end = (p1_hp_nx == '0) || (p2_hp_nx == '0) || (round_sec_nx == '0);

        if (p1_hp_nx > p2_hp_nx) begin
            winner_nx = WIN_P1;
        end else if (p2_hp_nx > p1_hp_nx) begin
            winner_nx = WIN_P2;
        end else begin
            winner_nx = WIN_DRAW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            tick_cnt    <= '0;
            players_rst <= 1'b1;
            ai_en       <= 1'b0;
            p1_hp       <= HP_INIT;
            p2_hp       <= HP_INIT;
            round_sec   <= SEC_INIT;
            winner      <= WIN_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tick_cnt <= '0;
                    if (start) begin
                        state_q   <= S_INTRO;
                        mode_q    <= mode_ai;
                        p1_hp     <= HP_INIT;
                        p2_hp     <= HP_INIT;
                        round_sec <= SEC_INIT;
                        winner    <= WIN_NONE;
                    end
                end

                S_INTRO: begin
                    if (tick) begin
                        if (tick_cnt == INTRO_LAST) begin
                            state_q     <= mode_q ? S_PVAI : S_PVP;
                            tick_cnt    <= '0;
                            players_rst <= 1'b0;
                            ai_en       <= mode_q;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                S_PVP, S_PVAI: begin
                    p1_hp     <= p1_hp_nx;
                    p2_hp     <= p2_hp_nx;
                    round_sec <= round_sec_nx;
                    if (fight_end) begin
                        state_q     <= S_OVER;
                        tick_cnt    <= '0;
                        players_rst <= 1'b1;
                        ai_en       <= 1'b0;
                        winner      <= winner_nx;
                    end else begin
                        tick_cnt <= fight_cnt_nx;
                    end
                end

                S_OVER: begin
                    if (tick) begin
                        if (tick_cnt == OVER_LAST) begin
                            state_q  <= S_IDLE;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    tick_cnt    <= '0;
                    players_rst <= 1'b1;
                    ai_en       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed match scenarios followed by random traffic,
// every cycle compared against a phase-level reference model.
module tb_match_controller;

    localparam int HP_W          = 4;
    localparam int HP_MAX        = 3;
    localparam int TICKS_PER_SEC = 2;
    localparam int ROUND_SEC     = 2;
    localparam int INTRO_TICKS   = 3;
    localparam int OVER_TICKS    = 2;

    logic            clk;
    logic            reset;
    logic            tick;
    logic            start;
    logic            mode_ai;
    logic            p1_hit;
    logic            p2_hit;
    logic [2:0]      state;
    logic            players_rst;
    logic            ai_en;
    logic [HP_W-1:0] p1_hp;
    logic [HP_W-1:0] p2_hp;
    logic [6:0]      round_sec;
    logic [1:0]      winner;

    int errors = 0;
    int checks = 0;

    // Reference model: phase number, ticks seen in this phase, health, clock, result.
    int m_phase;
    int m_ticks;
    int m_mode;
    int m_p1;
    int m_p2;
    int m_sec;
    int m_win;

    match_controller #(
        .HP_W(HP_W), .HP_MAX(HP_MAX), .TICKS_PER_SEC(TICKS_PER_SEC),
        .ROUND_SEC(ROUND_SEC), .INTRO_TICKS(INTRO_TICKS), .OVER_TICKS(OVER_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .mode_ai(mode_ai),
        .p1_hit(p1_hit), .p2_hit(p2_hit), .state(state), .players_rst(players_rst),
        .ai_en(ai_en), .p1_hp(p1_hp), .p2_hp(p2_hp), .round_sec(round_sec),
        .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ticks = 0;
        m_mode  = 0;
        m_p1    = HP_MAX;
        m_p2    = HP_MAX;
        m_sec   = ROUND_SEC;
        m_win   = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit m, input bit t,
                              input bit a, input bit b);
        if (r) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: if (s) begin
                m_phase = 1; m_ticks = 0; m_mode = m;
                m_p1 = HP_MAX; m_p2 = HP_MAX; m_sec = ROUND_SEC; m_win = 0;
            end
            1: if (t) begin
                m_ticks++;
                if (m_ticks == INTRO_TICKS) begin
                    m_phase = 2 + m_mode;
                    m_ticks = 0;
                end
            end
            2, 3: begin
                if (b) m_p1 = (m_p1 > 0) ? m_p1 - 1 : 0;
                if (a) m_p2 = (m_p2 > 0) ? m_p2 - 1 : 0;
                if (t) begin
                    m_ticks++;
                    if (m_ticks == TICKS_PER_SEC) begin
                        m_ticks = 0;
                        m_sec = (m_sec > 0) ? m_sec - 1 : 0;
                    end
                end
                if (m_p1 == 0 || m_p2 == 0 || m_sec == 0) begin
                    m_phase = 4;
                    m_ticks = 0;
                    m_win = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 3;
                end
            end
            default: if (t) begin
                m_ticks++;
                if (m_ticks == OVER_TICKS) begin
                    m_phase = 0;
                    m_ticks = 0;
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_phase));
        chk("players_rst", 32'(players_rst), (m_phase == 2 || m_phase == 3) ? 0 : 1);
        chk("ai_en", 32'(ai_en), (m_phase == 3) ? 1 : 0);
        chk("p1_hp", 32'(p1_hp), 32'(m_p1));
        chk("p2_hp", 32'(p2_hp), 32'(m_p2));
        chk("round_sec", 32'(round_sec), 32'(m_sec));
        chk("winner", 32'(winner), 32'(m_win));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check 1 time unit later.
    task automatic step(input bit r, input bit s, input bit m, input bit t,
                        input bit a, input bit b);
        reset = r; start = s; mode_ai = m; tick = t; p1_hit = a; p2_hit = b;
        @(posedge clk);
        model_step(r, s, m, t, a, b);
        #1;
        check_all();
        reset = 1'b0; start = 1'b0; tick = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode_ai = 1'b0; tick = 1'b0;
        p1_hit = 1'b0; p2_hit = 1'b0;
        model_reset();
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        chk("reset_state", 32'(state), 0);
        chk("reset_hp", 32'(p1_hp), HP_MAX);

        // PvP entry, then p1 wins on hits
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("t1_intro", 32'(state), 1);
        ticks(3);
        chk("t1_pvp", 32'(state), 2);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("t2_state", 32'(state), 4);
        chk("t2_winner", 32'(winner), 1);
        ticks(2);

        // draw on simultaneous final hits
        step(0, 1, 0, 0, 0, 0);
        ticks(3);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        chk("t3_winner", 32'(winner), 3);
        ticks(2);

        // timeout with p2 ahead
        step(0, 1, 0, 0, 0, 0);
        ticks(3);
        step(0, 0, 0, 0, 0, 1);
        ticks(4);
        chk("t4_sec", 32'(round_sec), 0);
        chk("t4_winner", 32'(winner), 2);

        // start ignored in GAME_OVER, then a PvAI match
        step(0, 1, 1, 0, 0, 0);
        chk("t5_ignored", 32'(state), 4);
        ticks(2);
        chk("t5_idle_hp", 32'(p1_hp), 2);
        step(0, 1, 1, 0, 0, 0);
        ticks(3);
        chk("t5_ai_en", 32'(ai_en), 1);

        // reset in the middle of a fight
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        ticks(2);
        chk("t6_pre_sec", 32'(round_sec), 1);
        step(1, 0, 0, 1, 1, 1);
        chk("t6_state", 32'(state), 0);
        chk("t6_sec", 32'(round_sec), ROUND_SEC);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
